// File: rtl/bus_read_buffer.sv
// bus_read_buffer
//   Per-PE receive stage on the shared PE data bus. A word granted by the
//   arbiter (rd_from_bus) arrives one cycle later on data_bus/addr_bus. It is
//   sorted into the FIFO of its source PE (addr_bus). The owning PE pops words
//   by source id.
//
// Ports
//   clk             clock
//   rst             synchronous reset, active-high
//   rd_from_bus     arbiter grant; bus word for this PE follows next cycle
//   data_bus        bus data, valid one cycle after rd_from_bus
//   addr_bus        source PE id, valid with data_bus
//   pop             pop request for FIFO pop_src
//   pop_src         source FIFO selected for pop
//   pop_data        popped word (registered, holds when pop_valid=0)
//   pop_valid       one-cycle pulse qualifying pop_data
//   empty           per-source FIFO empty
//   rd_buffer_full  per-source almost-full, to the arbiter
//   err             sticky dropped-write flag (overflow or bad source id)
module bus_read_buffer #(
  parameter int unsigned NUM_PE       = 8,
  parameter int unsigned DATA_LEN     = 16,
  parameter int unsigned BUS_ADDR_LEN = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SKID         = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_from_bus,
  input  logic [DATA_LEN-1:0]     data_bus,
  input  logic [BUS_ADDR_LEN-1:0] addr_bus,
  input  logic                    pop,
  input  logic [BUS_ADDR_LEN-1:0] pop_src,
  output logic [DATA_LEN-1:0]     pop_data,
  output logic                    pop_valid,
  output logic [NUM_PE-1:0]       empty,
  output logic [NUM_PE-1:0]       rd_buffer_full,
  output logic                    err
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FULL_T = FIFO_DEPTH - SKID;

  logic [DATA_LEN-1:0] mem    [NUM_PE][FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr [NUM_PE];
  logic [PTR_W-1:0]    rd_ptr [NUM_PE];
  logic [CNT_W-1:0]    count  [NUM_PE];

  logic                wr_pend;
  logic [NUM_PE-1:0]   wr_hit;
  logic [NUM_PE-1:0]   pop_hit;
  logic                wr_drop;
  logic [DATA_LEN-1:0] pop_word;

  // Per-FIFO decode; a source id outside 0..NUM_PE-1 hits no FIFO, so no
  // array is ever indexed out of range.
  always_comb begin
    wr_hit   = '0;
    pop_hit  = '0;
    pop_word = '0;
    for (int s = 0; s < NUM_PE; s++) begin
      wr_hit[s]  = wr_pend && (32'(addr_bus) == s) &&
                   (count[s] != CNT_W'(FIFO_DEPTH));
      // Pop qualified on the registered count only: no same-cycle bypass.
      pop_hit[s] = pop && (32'(pop_src) == s) && (count[s] != '0);
      if (pop_hit[s]) begin
        pop_word = mem[s][rd_ptr[s]];
      end
    end
    wr_drop = wr_pend && (wr_hit == '0);
  end

  // Status flags from registered counts.
  always_comb begin
    empty          = '0;
    rd_buffer_full = '0;
    for (int s = 0; s < NUM_PE; s++) begin
      empty[s]          = (count[s] == '0);
      rd_buffer_full[s] = (32'(count[s]) >= FULL_T);
    end
  end

  // Word storage; contents need no reset, pointers and counts gate access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NUM_PE; s++) begin
        if (wr_hit[s]) begin
          mem[s][wr_ptr[s]] <= data_bus;
        end
      end
    end
  end

  // Capture pipeline, pointers, counts, pop output and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend   <= 1'b0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
      err       <= 1'b0;
      for (int s = 0; s < NUM_PE; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      wr_pend   <= rd_from_bus;
      pop_valid <= (pop_hit != '0);
      if (pop_hit != '0) begin
        pop_data <= pop_word;
      end
      if (wr_drop) begin
        err <= 1'b1;
      end
      for (int s = 0; s < NUM_PE; s++) begin
        // Power-of-2 depth: pointers wrap naturally.
        if (wr_hit[s]) begin
          wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        end
        if (pop_hit[s]) begin
          rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        end
        case ({wr_hit[s], pop_hit[s]})
          2'b10:   count[s] <= count[s] + CNT_W'(1);
          2'b01:   count[s] <= count[s] - CNT_W'(1);
          default: count[s] <= count[s];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_read_buffer.sv
module tb_bus_read_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_from_bus;
  logic [15:0] data_bus;
  logic [2:0]  addr_bus;
  logic        pop;
  logic [2:0]  pop_src;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic [7:0]  empty;
  logic [7:0]  rd_buffer_full;
  logic        err;

  // Second instance with NUM_PE=6 for the bad-source-id case.
  logic        rd6;
  logic [2:0]  addr6;
  logic        pop6;
  logic [2:0]  pop_src6;
  logic [15:0] pop_data6;
  logic        pop_valid6;
  logic [5:0]  empty6;
  logic [5:0]  full6;
  logic        err6;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  bus_read_buffer u_dut (
    .clk(clk), .rst(rst), .rd_from_bus(rd_from_bus), .data_bus(data_bus),
    .addr_bus(addr_bus), .pop(pop), .pop_src(pop_src), .pop_data(pop_data),
    .pop_valid(pop_valid), .empty(empty), .rd_buffer_full(rd_buffer_full),
    .err(err)
  );

  bus_read_buffer #(.NUM_PE(6)) u_dut6 (
    .clk(clk), .rst(rst), .rd_from_bus(rd6), .data_bus(data_bus),
    .addr_bus(addr6), .pop(pop6), .pop_src(pop_src6), .pop_data(pop_data6),
    .pop_valid(pop_valid6), .empty(empty6), .rd_buffer_full(full6),
    .err(err6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop_valid pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && pop_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got valid data %0h expected no pop", pop_data);
      end else begin
        logic [15:0] exp;
        exp = sb_q.pop_front();
        if (pop_data !== exp) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", pop_data, exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] src, input logic [15:0] d);
    rd_from_bus = 1'b1;
    cyc();
    rd_from_bus = 1'b0;
    data_bus    = d;
    addr_bus    = src;
    cyc();
  endtask

  task automatic pop_exp(input logic [2:0] src, input logic [15:0] exp);
    pop     = 1'b1;
    pop_src = src;
    sb_q.push_back(exp);
    cyc();
    pop = 1'b0;
  endtask

  // Pop expected to fail: pop_valid must stay low.
  task automatic pop_none(input logic [2:0] src);
    pop     = 1'b1;
    pop_src = src;
    cyc();
    pop = 1'b0;
    @(negedge clk);
    chk("pop_none_valid", 32'(pop_valid), 32'd0);
    cyc();
  endtask

  // Push to psrc and pop from qsrc in the data cycle of the push.
  task automatic push_pop(input logic [2:0] psrc, input logic [15:0] d,
                          input logic [2:0] qsrc, input logic [15:0] exp);
    rd_from_bus = 1'b1;
    cyc();
    rd_from_bus = 1'b0;
    data_bus    = d;
    addr_bus    = psrc;
    pop         = 1'b1;
    pop_src     = qsrc;
    sb_q.push_back(exp);
    cyc();
    pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rd_from_bus = 1'b0; data_bus = '0; addr_bus = '0;
    pop = 1'b0; pop_src = '0;
    rd6 = 1'b0; addr6 = '0; pop6 = 1'b0; pop_src6 = '0;
    do_reset();
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_empty", 32'(empty), 32'hFF);
    chk("rst_full", 32'(rd_buffer_full), 32'h00);

    // 1: single capture to source 3
    push(3'd3, 16'hBEEF);
    chk("t1_empty3_before", 32'(empty[3]), 32'd0);
    pop_exp(3'd3, 16'hBEEF);
    chk("t1_empty_after", 32'(empty), 32'hFF);

    // 2: ordering and pointer wrap on source 5
    push(3'd5, 16'd1); push(3'd5, 16'd2); pop_exp(3'd5, 16'd1);
    push(3'd5, 16'd3); push(3'd5, 16'd4); pop_exp(3'd5, 16'd2);
    push(3'd5, 16'd5); push(3'd5, 16'd6); pop_exp(3'd5, 16'd3);
    chk("t2_full5", 32'(rd_buffer_full), 32'h20);
    pop_exp(3'd5, 16'd4); pop_exp(3'd5, 16'd5); pop_exp(3'd5, 16'd6);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_empty", 32'(empty), 32'hFF);

    // 3: almost-full and overflow on source 0
    push(3'd0, 16'hA1);
    chk("t3_full_cnt1", 32'(rd_buffer_full), 32'h00);
    push(3'd0, 16'hA2);
    chk("t3_full_cnt2", 32'(rd_buffer_full), 32'h01);
    chk("t3_empty_cnt2", 32'(empty), 32'hFE);
    push(3'd0, 16'hA3); push(3'd0, 16'hA4);
    chk("t3_err_cnt4", 32'(err), 32'd0);
    push(3'd0, 16'hA5);
    chk("t3_err_drop", 32'(err), 32'd1);
    pop_exp(3'd0, 16'hA1); pop_exp(3'd0, 16'hA2);
    pop_exp(3'd0, 16'hA3); pop_exp(3'd0, 16'hA4);
    pop_none(3'd0);
    chk("t3_err_held", 32'(err), 32'd1);
    do_reset();
    chk("t3_err_cleared", 32'(err), 32'd0);

    // 4: simultaneous push and pop
    push(3'd2, 16'h21);
    push_pop(3'd2, 16'h22, 3'd2, 16'h21);
    chk("t4_empty2", 32'(empty[2]), 32'd0);
    pop_exp(3'd2, 16'h22);
    chk("t4_empty2_after", 32'(empty[2]), 32'd1);
    push(3'd6, 16'h61);
    push_pop(3'd4, 16'h41, 3'd6, 16'h61);
    chk("t4_empty_4_6", 32'(empty), 32'hEF);
    pop_exp(3'd4, 16'h41);

    // 5: edge cases
    pop_none(3'd7);
    chk("t5_err_empty_pop", 32'(err), 32'd0);
    chk("t5_pop_data_hold", 32'(pop_data), 32'h41);
    rd6 = 1'b1;
    cyc();
    rd6 = 1'b0; addr6 = 3'd7; data_bus = 16'h7777;
    cyc();
    chk("t5_err6", 32'(err6), 32'd1);
    chk("t5_empty6", 32'(empty6), 32'h3F);
    chk("t5_err_main", 32'(err), 32'd0);

    // 6: reset between grant and data
    rd_from_bus = 1'b1;
    cyc();
    rd_from_bus = 1'b0; rst = 1'b1; data_bus = 16'h1234; addr_bus = 3'd1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_empty", 32'(empty), 32'hFF);
    chk("t6_full", 32'(rd_buffer_full), 32'h00);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_err6", 32'(err6), 32'd0);
    pop_none(3'd1);

    cyc(); cyc();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
